mbist_mem_responder: RTL and testbench

MBIST_MEM_RESPONDER -- requirements
Module: mbist_mem_responder

---
 rtl/mbist_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mbist_mem_responder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_mem_responder.sv
// Memory model answering a March BIST controller, with four programmable single-bit faults.
// Define MBIST_MEM_RESPONDER_INIT_EN to zero-fill the array (busy) after every reset.
module mbist_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_read,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  busy,
  input  logic                  fault_we,
  input  logic [1:0]            fault_idx,
  input  logic [MEM_AW-1:0]     fault_addr,
  input  logic [5:0]            fault_bit,
  input  logic [1:0]            fault_type,
  output logic [15:0]           fault_hits
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int NSLOT = 4;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_SA0  = 2'b01,
    FT_SA1  = 2'b10,
    FT_TF   = 2'b11
  } fault_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [5:0]        bit_pos;
    fault_e            ftype;
  } slot_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  slot_t                 slots_q [NSLOT];
  slot_t                 slots_d [NSLOT];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [15:0]           hits_q, hits_d;

  logic                  sweep_we;
  logic [MEM_AW-1:0]     sweep_addr;
  logic                  wr_acc, rd_acc, hit;
  logic [MEM_AW-1:0]     idx;
  logic [DATA_WIDTH-1:0] old_word, wr_word, rd_word, mask;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^address[ADDR_WIDTH-1:MEM_AW];

`ifdef MBIST_MEM_RESPONDER_INIT_EN
  typedef enum logic {ST_INIT, ST_READY} state_e;
  state_e            state_q, state_d;
  logic [MEM_AW-1:0] sweep_q, sweep_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign busy       = (state_q == ST_INIT);
  assign sweep_we   = busy;
  assign sweep_addr = sweep_q;
`else
  assign busy       = 1'b0;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
`endif

  // Slots are scanned in index order so a higher slot on the same bit overrides a lower one.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    idx      = address[MEM_AW-1:0];
    wr_acc   = mem_en && !busy && write_read;
    rd_acc   = mem_en && !busy && !write_read;
    old_word = mem_q[idx];
    wr_word  = wdata;
    rd_word  = old_word;
    hit      = 1'b0;
    mask     = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slots_q[i].ftype != FT_NONE && slots_q[i].addr == idx) begin
        hit  = 1'b1;
        mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << slots_q[i].bit_pos;
        case (slots_q[i].ftype)
          FT_SA0: begin
            wr_word = wr_word & ~mask;
            rd_word = rd_word & ~mask;
          end
          FT_SA1: begin
            wr_word = wr_word | mask;
            rd_word = rd_word | mask;
          end
          default: begin
            // A 0->1 transition cannot happen; every other case stores the new bit.
            wr_word = (wr_word & ~mask) | (wdata & old_word & mask);
            rd_word = (rd_word & ~mask) | (old_word & mask);
          end
        endcase
      end
    end

    mem_we    = sweep_we || wr_acc;
    mem_waddr = sweep_we ? sweep_addr : idx;
    mem_wdata = sweep_we ? '0 : wr_word;

    rdata_d       = rd_acc ? rd_word : rdata_q;
    rdata_valid_d = rd_acc;
    hits_d        = (rd_acc && hit && hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;

    for (int i = 0; i < NSLOT; i++) slots_d[i] = slots_q[i];
    if (fault_we) slots_d[fault_idx] = '{addr: fault_addr, bit_pos: fault_bit, ftype: fault_e'(fault_type)};
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      hits_q        <= '0;
      for (int i = 0; i < NSLOT; i++) slots_q[i] <= '0;
    end else begin
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      hits_q        <= hits_d;
      for (int i = 0; i < NSLOT; i++) slots_q[i] <= slots_d[i];
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the INIT sweep, not of rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault_hits  = hits_q;

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Self-checking bench for mbist_mem_responder: directed fault scenarios plus randomized
// traffic against a per-bit reference model of the faulty memory.
module tb_mbist_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic [15:0] address = '0;
  logic        write_read = 1'b0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        fault_we = 1'b0;
  logic [1:0]  fault_idx = '0;
  logic [7:0]  fault_addr = '0;
  logic [5:0]  fault_bit = '0;
  logic [1:0]  fault_type = '0;
  logic [15:0] fault_hits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbist_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .address(address), .write_read(write_read),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
    .fault_we(fault_we), .fault_idx(fault_idx), .fault_addr(fault_addr),
    .fault_bit(fault_bit), .fault_type(fault_type), .fault_hits(fault_hits)
  );

  // Reference model: fault table, word contents and expected outputs.
  logic [7:0]  m_addr [4];
  logic [5:0]  m_bit  [4];
  logic [1:0]  m_type [4];
  logic [63:0] m_mem  [256];
  bit          m_known[256];
  logic [63:0] exp_rdata;
  bit          exp_valid;
  logic [15:0] exp_hits;

  function automatic int winning_slot(input logic [7:0] a, input int b);
    int w = -1;
    for (int i = 0; i < 4; i++)
      if (m_type[i] != 2'b00 && m_addr[i] == a && int'(m_bit[i]) == b) w = i;
    return w;
  endfunction

  function automatic logic [63:0] model_write(input logic [7:0] a, input logic [63:0] d);
    logic [63:0] old, r;
    int s;
    old = m_mem[a];
    r = d;
    for (int b = 0; b < 64; b++) begin
      s = winning_slot(a, b);
      if (s >= 0) begin
        case (m_type[s])
          2'b01:   r[b] = 1'b0;
          2'b10:   r[b] = 1'b1;
          default: r[b] = (old[b] == 1'b0 && d[b] == 1'b1) ? 1'b0 : d[b];
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] model_read(input logic [7:0] a);
    logic [63:0] r;
    int s;
    r = m_mem[a];
    for (int b = 0; b < 64; b++) begin
      s = winning_slot(a, b);
      if (s >= 0 && m_type[s] == 2'b01) r[b] = 1'b0;
      if (s >= 0 && m_type[s] == 2'b10) r[b] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit any_hit(input logic [7:0] a);
    bit h = 1'b0;
    for (int i = 0; i < 4; i++) if (m_type[i] != 2'b00 && m_addr[i] == a) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_bit[i] = '0; m_type[i] = 2'b00;
    end
    exp_rdata = '0; exp_valid = 1'b0; exp_hits = '0;
    for (int i = 0; i < 256; i++) begin
`ifdef MBIST_MEM_RESPONDER_INIT_EN
      m_mem[i] = '0; m_known[i] = 1'b1;
`else
      m_known[i] = 1'b0;
`endif
    end
  endtask

  // One clock of stimulus; model updated with pre-edge slot contents, outputs sampled #1 after the edge.
  task automatic drive(input bit en, input bit we, input logic [15:0] a, input logic [63:0] d,
                       input bit fwe, input logic [1:0] fi, input logic [7:0] fa,
                       input logic [5:0] fb, input logic [1:0] ft);
    logic [7:0] w;
    w = a[7:0];
    mem_en = en; write_read = we; address = a; wdata = d;
    fault_we = fwe; fault_idx = fi; fault_addr = fa; fault_bit = fb; fault_type = ft;
    exp_valid = en && !we;
    if (en && we) begin
      m_mem[w] = model_write(w, d);
      m_known[w] = 1'b1;
    end
    if (en && !we) begin
      exp_rdata = model_read(w);
      if (any_hit(w) && exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
    end
    if (fwe) begin
      m_addr[fi] = fa; m_bit[fi] = fb; m_type[fi] = ft;
    end
    @(posedge clk); #1;
    mem_en = 1'b0; fault_we = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 2'd0, 8'd0, 6'd0, 2'd0);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 64'd0, 1'b0, 2'd0, 8'd0, 6'd0, 2'd0);
  endtask

  task automatic prog(input logic [1:0] i, input logic [7:0] a, input logic [5:0] b, input logic [1:0] t);
    drive(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, i, a, b, t);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (rdata !== 64'd0 || rdata_valid !== 1'b0 || fault_hits !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h valid=%b hits=%h, required 0/0/0", rdata, rdata_valid, fault_hits);
    end
`ifdef MBIST_MEM_RESPONDER_INIT_EN
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: busy=%b, required 1", busy); end
`else
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
`endif
  endtask

  task automatic test_init();
`ifdef MBIST_MEM_RESPONDER_INIT_EN
    int n;
    bit saw_valid;
    n = 0; saw_valid = 1'b0;
    rst = 1'b0;
    while (busy === 1'b1 && n < 1000) begin
      if (rdata_valid === 1'b1) saw_valid = 1'b1;
      mem_en = 1'b0; fault_we = 1'b0;
      if (n == 10) begin
        fault_we = 1'b1; fault_idx = 2'd2; fault_addr = 8'h30; fault_bit = 6'd4; fault_type = 2'b10;
        m_addr[2] = 8'h30; m_bit[2] = 6'd4; m_type[2] = 2'b10;
      end
      if (n == 100) begin mem_en = 1'b1; write_read = 1'b1; address = 16'h0005; wdata = '1; end
      if (n == 101) begin mem_en = 1'b1; write_read = 1'b0; address = 16'h0005; end
      n++;
      @(posedge clk); #1;
    end
    mem_en = 1'b0; fault_we = 1'b0;
    checks++;
    if (n != 256) begin errors++; $display("FAIL init_busy_len: busy cycles=%0d, required 256", n); end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL init_valid_while_busy: rdata_valid=1 seen, required 0"); end
    rd(16'h00FF);
    checks++;
    if (rdata !== 64'd0 || rdata_valid !== 1'b1) begin
      errors++; $display("FAIL init_read_ff: rdata=%h valid=%b, required 0 valid 1", rdata, rdata_valid);
    end
    rd(16'h0005);
    checks++;
    if (rdata !== 64'd0) begin errors++; $display("FAIL init_dropped_write: rdata=%h, required 0", rdata); end
    rd(16'h0030);
    checks++;
    if (rdata !== 64'h10 || fault_hits !== exp_hits) begin
      errors++; $display("FAIL init_fault_we: rdata=%h hits=%h, required 10 hits %h", rdata, fault_hits, exp_hits);
    end
    // Reset part way through a second sweep must restart the full 256-cycle busy window.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (50) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != 256) begin errors++; $display("FAIL init_restart_len: busy cycles=%0d, required 256", n); end
    checks++;
    if (fault_hits !== 16'd0) begin errors++; $display("FAIL init_restart_hits: hits=%h, required 0", fault_hits); end
`else
    bit saw_busy;
    saw_busy = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy !== 1'b0) saw_busy = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_busy) begin errors++; $display("FAIL noinit_busy: busy seen high, required constant 0"); end
    wr(16'h0005, 64'h0123_4567_89AB_CDEF);
    rd(16'h0005);
    checks++;
    if (rdata !== 64'h0123_4567_89AB_CDEF || rdata_valid !== 1'b1) begin
      errors++; $display("FAIL noinit_first_access: rdata=%h valid=%b, required 0123456789abcdef valid 1", rdata, rdata_valid);
    end
`endif
  endtask

  task automatic test_basic();
    wr(16'h0010, 64'hA5A5_A5A5_A5A5_A5A5);
    checks++;
    if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_write_valid: valid=%b, required 0", rdata_valid); end
    rd(16'h0010);
    checks++;
    if (rdata !== 64'hA5A5_A5A5_A5A5_A5A5 || rdata_valid !== 1'b1 || fault_hits !== 16'd0) begin
      errors++;
      $display("FAIL basic_read: rdata=%h valid=%b hits=%h, required a5a5a5a5a5a5a5a5 valid 1 hits 0", rdata, rdata_valid, fault_hits);
    end
  endtask

  task automatic test_sa1();
    prog(2'd0, 8'h10, 6'd0, 2'b10);
    wr(16'h0010, 64'd0);
    rd(16'h0010);
    checks++;
    if (rdata !== 64'h1 || fault_hits !== 16'd1) begin
      errors++; $display("FAIL sa1_read: rdata=%h hits=%h, required 1 hits 1", rdata, fault_hits);
    end
  endtask

  task automatic test_tf();
    prog(2'd1, 8'h20, 6'd63, 2'b11);
    wr(16'h0020, 64'd0);
    wr(16'h0020, 64'h8000_0000_0000_0000);
    rd(16'h0020);
    checks++;
    if (rdata !== 64'd0 || fault_hits !== exp_hits) begin
      errors++; $display("FAIL tf_read: rdata=%h hits=%h, required 0 hits %h", rdata, fault_hits, exp_hits);
    end
    prog(2'd3, 8'h20, 6'd63, 2'b10);
    rd(16'h0020);
    checks++;
    if (rdata !== 64'h8000_0000_0000_0000 || fault_hits !== exp_hits) begin
      errors++; $display("FAIL tf_sa1_override: rdata=%h hits=%h, required 8000000000000000 hits %h", rdata, fault_hits, exp_hits);
    end
  endtask

  task automatic test_alias_hold();
    wr(16'h0110, 64'h1234_5678_9ABC_DEF0);
    rd(16'h0010);
    checks++;
    if (rdata !== 64'h1234_5678_9ABC_DEF1 || rdata_valid !== 1'b1) begin
      errors++; $display("FAIL alias_read: rdata=%h valid=%b, required 123456789abcdef1 valid 1", rdata, rdata_valid);
    end
    wr(16'h0077, 64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0010, 64'd0, 1'b0, 2'd0, 8'd0, 6'd0, 2'd0);
      checks++;
      if (rdata !== 64'h1234_5678_9ABC_DEF1 || rdata_valid !== 1'b0) begin
        errors++; $display("FAIL idle_hold: rdata=%h valid=%b, required 123456789abcdef1 valid 0", rdata, rdata_valid);
      end
    end
  endtask

  task automatic test_same_cycle_slot();
    wr(16'h0040, 64'h8);
    drive(1'b1, 1'b0, 16'h0040, 64'd0, 1'b1, 2'd2, 8'h40, 6'd3, 2'b01);
    checks++;
    if (rdata !== 64'h8 || fault_hits !== exp_hits) begin
      errors++; $display("FAIL same_cycle_old_slot: rdata=%h hits=%h, required 8 hits %h", rdata, fault_hits, exp_hits);
    end
    rd(16'h0040);
    checks++;
    if (rdata !== 64'h0 || fault_hits !== exp_hits) begin
      errors++; $display("FAIL same_cycle_new_slot: rdata=%h hits=%h, required 0 hits %h", rdata, fault_hits, exp_hits);
    end
  endtask

  task automatic test_reset_mid_access();
    wr(16'h0050, 64'hDEAD_BEEF_0000_0001);
    rd(16'h0050);
    checks++;
    if (rdata_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre: valid=%b, required 1", rdata_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 64'd0 || fault_hits !== 16'd0) begin
      errors++; $display("FAIL midreset_abort: valid=%b rdata=%h hits=%h, required 0/0/0", rdata_valid, rdata, fault_hits);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    wait_ready("midreset");
  endtask

  task automatic test_random();
    logic [7:0]  hi, lo, fa;
    logic [63:0] d;
    logic [5:0]  fb;
    int          op;
    for (int i = 0; i < 8; i++) begin
      hi = 8'($urandom_range(0, 255));
      wr({hi, 8'h80 + 8'(i)}, {$urandom, $urandom});
    end
    for (int n = 0; n < 1500; n++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'h80 + 8'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      op = $urandom_range(0, 9);
      fa = 8'h80 + 8'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: fb = 6'd0;
        1: fb = 6'd1;
        2: fb = 6'd63;
        default: fb = 6'($urandom_range(0, 63));
      endcase
      drive(op != 0, op >= 1 && op <= 4, {hi, lo}, d, $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)), fa, fb, 2'($urandom_range(0, 3)));
      checks++;
      if (rdata_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: valid=%b, required %b", n, rdata_valid, exp_valid);
      end
      checks++;
      if (rdata !== exp_rdata) begin
        errors++; $display("FAIL rand_rdata[%0d]: rdata=%h, required %h", n, rdata, exp_rdata);
      end
      checks++;
      if (fault_hits !== exp_hits) begin
        errors++; $display("FAIL rand_hits[%0d]: hits=%h, required %h", n, fault_hits, exp_hits);
      end
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    wait_ready("saturate");
    prog(2'd0, 8'h77, 6'd0, 2'b01);
    wr(16'h0077, '1);
    mem_en = 1'b1; write_read = 1'b0; address = 16'h0077;
    for (int i = 1; i <= 65540; i++) begin
      @(posedge clk); #1;
      exp_hits = (i > 65535) ? 16'hFFFF : 16'(i);
      if (i == 1 || i == 65534 || i == 65535 || i == 65536 || i == 65540) begin
        checks++;
        if (fault_hits !== exp_hits) begin
          errors++; $display("FAIL saturate_hits[%0d]: hits=%h, required %h", i, fault_hits, exp_hits);
        end
      end
    end
    mem_en = 1'b0;
    checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFFE || rdata_valid !== 1'b1) begin
      errors++; $display("FAIL saturate_rdata: rdata=%h valid=%b, required fffffffffffffffe valid 1", rdata, rdata_valid);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_sa1();
    test_tf();
    test_alias_hold();
    test_same_cycle_slot();
    test_reset_mid_access();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
